ternary_matvec: RTL and testbench

Sequential ternary matrix-vector multiply engine that sits beside the register file. It reads one source vector register and the ternary matrix register, and computes y = W·x one row group per cycle. It then writes y back into a destination vector register through the register file's per-register write-enable port. It is the execution stage for the AFU's matmul command.

---
 rtl/ternary_matvec_pkg.sv | 16 +
 rtl/ternary_matvec_if.sv | 12 +
 rtl/ternary_matvec_dot.sv | 16 +
 rtl/ternary_matvec.sv | 79 +++++++
 tb/tb_ternary_matvec.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/ternary_matvec_pkg.sv
// ternary_matvec_pkg: sizes, element/vector/matrix/trit types and accumulator width for the ternary matvec engine
package ternary_matvec_pkg;
  localparam int VectorLength = 4;
  localparam int ElemWidth = 8;
  localparam int NumVectorRegisters = 4;
  localparam int AccWidth = ElemWidth + $clog2(VectorLength) + 1;
  typedef logic signed [ElemWidth-1:0] elem_t;
  typedef elem_t [VectorLength-1:0] vector_t;
  typedef logic [1:0] trit_t;
  typedef trit_t [VectorLength-1:0][VectorLength-1:0] ternary_matrix_t;
  typedef logic signed [AccWidth-1:0] acc_t;
  typedef logic [$clog2(NumVectorRegisters)-1:0] reg_idx_t;
  localparam trit_t TritZero = 2'b00;
  localparam trit_t TritPos = 2'b01;
  localparam trit_t TritNeg = 2'b11;
endpackage

// File: rtl/ternary_matvec_if.sv
// ternary_matvec_if: command handshake (start/ready/src_idx/dst_idx) and register-file write port (w_v_en/w_v_data/done)
interface ternary_matvec_if import ternary_matvec_pkg::*; ();
  logic start;
  logic ready;
  reg_idx_t src_idx;
  reg_idx_t dst_idx;
  logic [NumVectorRegisters-1:0] w_v_en;
  vector_t w_v_data [NumVectorRegisters];
  logic done;
  modport master (output start, src_idx, dst_idx, input ready, w_v_en, w_v_data, done);
  modport slave (input start, src_idx, dst_idx, output ready, w_v_en, w_v_data, done);
endinterface

// File: rtl/ternary_matvec_dot.sv
// ternary_dot: combinational trit-row by vector dot product (row, x in; wrapped ElemWidth y out)
module ternary_dot
  import ternary_matvec_pkg::*;
(
  input  trit_t [VectorLength-1:0] row,
  input  vector_t                  x,
  output elem_t                    y
);
  acc_t acc;
  always_comb begin
    acc = '0;
    for (int c = 0; c < VectorLength; c++)
      acc = row[c] == TritPos ? acc + acc_t'(x[c]) : row[c] == TritNeg ? acc - acc_t'(x[c]) : acc;
    y = acc[ElemWidth-1:0];
  end
endmodule

// File: rtl/ternary_matvec.sv
// ternary_matvec: y = W*x engine; clk_i/rst_i, register-file read data in, command + write port on bus
module ternary_matvec
  import ternary_matvec_pkg::*;
#(
  parameter int RowsPerCycle = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  vector_t         r_v_data_i [NumVectorRegisters],
  input  ternary_matrix_t r_tm_data_i,
  ternary_matvec_if.slave bus
);
  localparam int G = VectorLength / RowsPerCycle;
  localparam int CntW = G > 1 ? $clog2(G) : 1;
  localparam int RowW = VectorLength > 1 ? $clog2(VectorLength) : 1;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [RowW-1:0] row_t;
  typedef enum logic [1:0] {IDLE, COMPUTE, WRITE} state_t;
  state_t state, state_n;
  cnt_t cnt, cnt_n;
  vector_t x_q, y_q;
  ternary_matrix_t w_q;
  reg_idx_t dst_q;
  logic ready_q, done_q, accept;
  logic [NumVectorRegisters-1:0] en_q;
  row_t row_idx [RowsPerCycle];
  elem_t dot_y [RowsPerCycle];
  assign accept = bus.start && ready_q;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: begin
        state_n = accept ? COMPUTE : IDLE;
        cnt_n = '0;
      end
      COMPUTE: begin
        state_n = cnt == cnt_t'(G - 1) ? WRITE : COMPUTE;
        cnt_n = cnt + cnt_t'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  for (genvar g = 0; g < RowsPerCycle; g++) begin : g_dot
    assign row_idx[g] = row_t'(int'(cnt) * RowsPerCycle + g);
    ternary_dot u_dot (.row(w_q[row_idx[g]]), .x(x_q), .y(dot_y[g]));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      ready_q <= 1'b1;
      done_q <= 1'b0;
      en_q <= '0;
      y_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ready_q <= state_n == IDLE;
      done_q <= state_n == WRITE;
      en_q <= state_n == WRITE ? NumVectorRegisters'(1) << dst_q : '0;
      if (state == COMPUTE)
        for (int i = 0; i < RowsPerCycle; i++) y_q[row_idx[i]] <= dot_y[i];
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept) begin
      x_q <= r_v_data_i[bus.src_idx];
      w_q <= r_tm_data_i;
      dst_q <= bus.dst_idx;
    end
  end
  assign bus.ready = ready_q;
  assign bus.done = done_q;
  assign bus.w_v_en = en_q;
  for (genvar v = 0; v < NumVectorRegisters; v++) begin : g_lane
    assign bus.w_v_data[v] = y_q;
  end
endmodule

// File: tb/tb_ternary_matvec.sv
// tb_ternary_matvec: directed vectors with a write-port scoreboard for ternary_matvec
module tb_ternary_matvec;
  import ternary_matvec_pkg::*;
  typedef trit_t [VectorLength-1:0] row_t;
  typedef struct {
    logic [NumVectorRegisters-1:0] en;
    vector_t y;
    int wcyc;
  } exp_t;
  localparam trit_t P = TritPos;
  localparam trit_t N = TritNeg;
  localparam trit_t Z = TritZero;
  localparam trit_t R = 2'b10;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  vector_t rf [NumVectorRegisters];
  ternary_matrix_t tm;
  ternary_matvec_if bus ();
  ternary_matvec #(.RowsPerCycle(1)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .r_v_data_i(rf),
    .r_tm_data_i(tm),
    .bus(bus.slave)
  );
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  int checks = 0, errors = 0, writes = 0, pushed = 0;
  exp_t sb[$];
  exp_t e;
  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic vector_t mkv(int a, int b, int c, int d);
    return {elem_t'(d), elem_t'(c), elem_t'(b), elem_t'(a)};
  endfunction
  function automatic row_t mkr(trit_t a, trit_t b, trit_t c, trit_t d);
    return {d, c, b, a};
  endfunction
  function automatic ternary_matrix_t mkm(row_t a, row_t b, row_t c, row_t d);
    return {d, c, b, a};
  endfunction
  task automatic push(reg_idx_t dst, vector_t y, int t);
    sb.push_back('{en: NumVectorRegisters'(1) << dst, y: y, wcyc: t + 4});
    pushed++;
  endtask
  always @(negedge clk_i) begin
    if (bus.w_v_en != '0 || bus.done) begin
      writes++;
      if (sb.size() == 0) check("unexpected_write", {bus.w_v_en, bus.done}, '0);
      else begin
        e = sb.pop_front();
        check("w_v_en", bus.w_v_en, e.en);
        check("done", bus.done, 1);
        check("write_cycle", cyc, e.wcyc);
        for (int i = 0; i < NumVectorRegisters; i++) check("w_v_data", bus.w_v_data[i], e.y);
      end
    end
  end
  task automatic issue(reg_idx_t src, reg_idx_t dst, vector_t y, bit ovr, vector_t ox, ternary_matrix_t ow);
    int t;
    bus.src_idx = src;
    bus.dst_idx = dst;
    bus.start = 1'b1;
    check("accept_ready", bus.ready, 1);
    t = cyc + 1;
    push(dst, y, t);
    @(posedge clk_i);
    #1 bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("busy_ready", bus.ready, 0);
      if (ovr && cyc == t + 1) begin
        rf[src] = ox;
        tm = ow;
      end
    end
    @(negedge clk_i);
    check("ready_back", bus.ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1);
  end
  initial begin
    int t1, t2, t;
    bit got;
    bus.start = 1'b0;
    bus.src_idx = '0;
    bus.dst_idx = '0;
    rf[0] = mkv(1, 2, 3, 4);
    rf[1] = mkv(5, 3, 7, -2);
    rf[2] = mkv(10, 20, 30, 40);
    rf[3] = mkv(100, 100, 100, 100);
    tm = mkm(mkr(P, Z, Z, Z), mkr(Z, P, Z, Z), mkr(Z, Z, P, Z), mkr(Z, Z, Z, P));
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_ready", bus.ready, 1);
    check("rst_en", bus.w_v_en, 0);
    check("rst_done", bus.done, 0);
    check("rst_data", bus.w_v_data[0], 0);
    @(negedge clk_i);
    issue(0, 1, mkv(1, 2, 3, 4), 0, '0, '0);
    tm = mkm(mkr(P, N, Z, P), mkr(N, N, N, N), mkr(Z, Z, Z, Z), mkr(R, P, P, Z));
    issue(1, 3, mkv(0, -13, 0, 10), 0, '0, '0);
    tm = mkm(mkr(P, P, P, P), mkr(P, P, P, P), mkr(P, P, P, P), mkr(P, P, P, P));
    issue(3, 0, mkv(-112, -112, -112, -112), 0, '0, '0);
    tm = mkm(mkr(P, P, Z, Z), mkr(N, Z, Z, Z), mkr(Z, Z, P, N), mkr(P, N, P, N));
    issue(2, 2, mkv(30, -10, -10, -20), 1, mkv(1, 1, 1, 1),
          mkm(mkr(P, Z, Z, Z), mkr(Z, P, Z, Z), mkr(Z, Z, P, Z), mkr(Z, Z, Z, P)));
    bus.src_idx = 0;
    bus.dst_idx = 3;
    bus.start = 1'b1;
    check("held_accept_ready", bus.ready, 1);
    t1 = cyc + 1;
    push(3, mkv(1, 2, 3, 4), t1);
    @(posedge clk_i);
    #1;
    bus.src_idx = 1;
    bus.dst_idx = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk_i);
      got = bus.ready;
    end
    t2 = cyc + 1;
    check("held_rearm_seen", got, 1);
    check("held_rearm_cycle", t2, t1 + 6);
    push(0, mkv(5, 3, 7, -2), t2);
    @(posedge clk_i);
    #1 bus.start = 1'b0;
    repeat (7) @(negedge clk_i);
    check("held_ready_back", bus.ready, 1);
    bus.src_idx = 0;
    bus.dst_idx = 1;
    bus.start = 1'b1;
    check("rstmid_accept_ready", bus.ready, 1);
    t = cyc + 1;
    @(posedge clk_i);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rstmid_cycle", cyc, t + 2);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rstmid_ready", bus.ready, 1);
    check("rstmid_en", bus.w_v_en, 0);
    check("rstmid_data", bus.w_v_data[1], 0);
    repeat (6) @(negedge clk_i);
    check("rstmid_idle", bus.ready, 1);
    tm = mkm(mkr(P, P, P, P), mkr(P, P, P, P), mkr(P, P, P, P), mkr(P, P, P, P));
    issue(3, 2, mkv(-112, -112, -112, -112), 0, '0, '0);
    repeat (3) @(negedge clk_i);
    check("write_count", writes, pushed);
    check("queue_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
